// File: rtl/uart_pkg.sv
// uart_pkg: shared types, LSR bit positions and trigger decode for the UART RX path.
//   rx_entry_t  : one stored character with its error flags
//   rx_trig_t   : trig_sel encoding
//   trig_level  : trigger threshold for a given FIFO depth
package uart_pkg;

    localparam int UART_DW = 8;

    typedef struct packed {
        logic [UART_DW-1:0] data;
        logic               pe;
        logic               fe;
        logic               bi;
    } rx_entry_t;

    typedef enum logic [1:0] {
        TRIG_ONE  = 2'b00,
        TRIG_QTR  = 2'b01,
        TRIG_HALF = 2'b10,
        TRIG_NEAR = 2'b11
    } rx_trig_t;

    localparam int LSR_DR      = 0;
    localparam int LSR_OE      = 1;
    localparam int LSR_PE      = 2;
    localparam int LSR_FE      = 3;
    localparam int LSR_BI      = 4;
    localparam int LSR_FIFOERR = 7;

    function automatic int trig_level(input rx_trig_t t, input int depth);
        return (t == TRIG_ONE)  ? 1 :
               (t == TRIG_QTR)  ? depth / 4 :
               (t == TRIG_HALF) ? depth / 2 : depth - 2;
    endfunction

endpackage

// File: rtl/uart_rx_tocnt.sv
// uart_rx_tocnt: character-timeout counter with sticky fire output.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clears the count and the fire flag
//   i_tick   : baud oversample tick, advances the count
//   o_fire   : set on the tick that reaches TIMEOUT_TICKS, held until i_clr
module uart_rx_tocnt #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_fire
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] r_cnt;
    logic          r_fire;

    // Saturates at TMAX so fire is raised exactly once per idle period.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt  <= '0;
            r_fire <= 1'b0;
        end else if (i_tick && r_cnt != TMAX) begin
            r_cnt <= r_cnt + TW'(1);
            if (r_cnt == TMAX - TW'(1)) r_fire <= 1'b1;
        end
    end

    assign o_fire = r_fire;

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 16550-style RX FIFO with per-character error flags, LSR and RX interrupts.
//   clk, rst            : clock, synchronous active-high reset
//   baud_pulse          : oversample tick for the character timeout
//   fifo_en, flush      : FIFO/16450 mode select, RX FIFO reset pulse
//   trig_sel            : rda trigger level select
//   push, din, *_in     : character and error flags from the deserialiser
//   pop, lsr_rd         : RBR and LSR read strobes
//   dout, count, lsr    : head character, occupancy, line status
//   rda_irq, cti_irq    : data-available and character-timeout interrupts
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int DW            = 8,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_pulse,
    input  logic                       fifo_en,
    input  logic                       flush,
    input  logic [1:0]                 trig_sel,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pe_in,
    input  logic                       fe_in,
    input  logic                       bi_in,
    input  logic                       pop,
    input  logic                       lsr_rd,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 lsr,
    output logic                       rda_irq,
    output logic                       cti_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
        logic          bi;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt, r_err;
    logic          r_oe, r_fen;
    rx_trig_t      r_trig;

    entry_t        w_head, w_in;
    logic [CW-1:0] w_trig;
    logic          w_flush, w_empty, w_full, w_do_push, w_do_pop, w_ovwr, w_oe_set;

    assign w_head  = r_mem[r_rd];
    assign w_in    = '{data: din, pe: pe_in, fe: fe_in, bi: bi_in};
    // A mode change flushes in the cycle the new fifo_en is first seen.
    assign w_flush = flush || (fifo_en != r_fen);
    assign w_empty = (r_cnt == '0);
    assign w_full  = r_fen ? (r_cnt == CW'(DEPTH)) : !w_empty;

    // A pop frees a slot in the same cycle, so push+pop while full is not an overrun.
    assign w_do_pop  = !w_flush && pop && !w_empty;
    assign w_do_push = !w_flush && push && (!w_full || w_do_pop);
    assign w_ovwr    = !w_flush && push && w_full && !w_do_pop && !r_fen;
    assign w_oe_set  = !w_flush && push && w_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= w_in;
        if (w_ovwr)    r_mem[r_rd] <= w_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_err  <= '0;
            r_oe   <= 1'b0;
            r_fen  <= fifo_en;
            r_trig <= rx_trig_t'(trig_sel);
        end else begin
            r_fen  <= fifo_en;
            r_trig <= rx_trig_t'(trig_sel);
            r_oe   <= w_oe_set ? 1'b1 : (lsr_rd ? 1'b0 : r_oe);
            if (w_flush) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
                r_err <= '0;
            end else begin
                if (w_do_push) r_wr <= r_wr + AW'(1);
                if (w_do_pop)  r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_do_push && !w_do_pop) - CW'(w_do_pop && !w_do_push);
                // An overwrite both removes the old head's flag and adds the new one.
                r_err <= r_err + CW'((w_do_push || w_ovwr) && (pe_in || fe_in || bi_in))
                               - CW'((w_do_pop || w_ovwr) && (w_head.pe || w_head.fe || w_head.bi));
            end
        end
    end

    assign w_trig  = r_fen ? CW'(trig_level(r_trig, DEPTH)) : CW'(1);
    assign count   = r_cnt;
    assign dout    = w_empty ? '0 : w_head.data;
    assign rda_irq = (r_cnt >= w_trig);

    always_comb begin
        lsr              = 8'h00;
        lsr[LSR_DR]      = !w_empty;
        lsr[LSR_OE]      = r_oe;
        lsr[LSR_PE]      = !w_empty && w_head.pe;
        lsr[LSR_FE]      = !w_empty && w_head.fe;
        lsr[LSR_BI]      = !w_empty && w_head.bi;
        lsr[LSR_FIFOERR] = (r_err != '0);
    end

    uart_rx_tocnt #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_tocnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (push || pop || w_flush || w_empty || !r_fen),
        .i_tick (baud_pulse),
        .o_fire (cti_irq)
    );

endmodule
